// File: rtl/riscy_pkg.sv
// Shared RV32 definitions: datapath width, opcode constants, M-extension op
// and sequencer state encodings.
package riscy_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // funct3 encoding of the RV32M ops
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    // True for the four divide/remainder ops
    function automatic logic is_div(input mdu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Request/response bundle between the core (master) and the mul/div sequencer (slave).
interface mdu_seq_if #(
    parameter int XLEN  = riscy_pkg::XLEN,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [XLEN-1:0]  req_rs1;
    logic [XLEN-1:0]  req_rs2;
    logic [TAG_W-1:0] req_rd;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_result;
    logic [TAG_W-1:0] resp_rd;
    logic             busy;

    modport master (
        output flush, req_valid, req_funct3, req_rs1, req_rs2, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_rd, busy
    );

    modport slave (
        input  flush, req_valid, req_funct3, req_rs1, req_rs2, req_rd, resp_ready,
        output req_ready, resp_valid, resp_result, resp_rd, busy
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the unsigned datapath: a radix-2 shift-add multiply step
// (acc:lo is the product, lo[0] the current multiplier bit) or a restoring
// divide step (acc is the partial remainder, lo shifts dividend out / quotient in).
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            i_mode_div,
    input  logic [XLEN:0]   i_acc,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_opnd,
    output logic [XLEN:0]   o_acc,
    output logic [XLEN-1:0] o_lo
);
    logic [XLEN:0]   w_sum;
    logic [XLEN+1:0] w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;

    // Both step flavours computed in parallel, mode picks the one to commit
    always_comb begin
        w_sum   = {1'b0, i_acc[XLEN-1:0]} + (i_lo[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
        w_shift = {i_acc, i_lo[XLEN-1]};
        w_ge    = (w_shift >= {2'b00, i_opnd});
        w_diff  = w_shift[XLEN:0] - {1'b0, i_opnd};
        if (i_mode_div) begin
            o_acc = w_ge ? w_diff : w_shift[XLEN:0];
            o_lo  = {i_lo[XLEN-2:0], w_ge};
        end else begin
            o_acc = {1'b0, w_sum[XLEN:1]};
            o_lo  = {w_sum[0], i_lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/mdu_seq.sv
// RV32M multiply/divide sequencer: accepts one op, iterates one bit per
// cycle on operand magnitudes, fixes the sign at the end and holds the
// result until the consumer takes it.
module mdu_seq #(
    parameter int XLEN  = riscy_pkg::XLEN,
    parameter int TAG_W = 5
) (
    input logic        clk,
    input logic        rst_n,
    mdu_seq_if.slave   bus
);
    import riscy_pkg::*;

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST_IT  = CW'(XLEN-1);

    mdu_state_e       r_state;
    mdu_op_e          r_op;
    logic             r_neg;
    logic [CW-1:0]    r_cnt;
    logic [XLEN:0]    r_acc;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_opnd;
    logic [XLEN-1:0]  r_result;
    logic [TAG_W-1:0] r_rd;

    mdu_op_e           w_op;
    logic              w_neg1, w_neg2, w_neg_req;
    logic [XLEN-1:0]   w_mag1, w_mag2;
    logic              w_div_zero, w_ovf;
    logic [XLEN-1:0]   w_fast_result;
    logic [XLEN:0]     w_acc_next;
    logic [XLEN-1:0]   w_lo_next;
    logic [XLEN-1:0]   w_rem;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_final;

    // Request decode: operand magnitudes, result sign and the fast-path cases
    always_comb begin
        w_op      = mdu_op_e'(bus.req_funct3);
        w_neg1    = (w_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.req_rs1[XLEN-1];
        w_neg2    = (w_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && bus.req_rs2[XLEN-1];
        w_mag1    = w_neg1 ? -bus.req_rs1 : bus.req_rs1;
        w_mag2    = w_neg2 ? -bus.req_rs2 : bus.req_rs2;
        w_neg_req = (w_op inside {OP_MULHSU, OP_REM}) ? w_neg1 : (w_neg1 ^ w_neg2);
        w_div_zero = is_div(w_op) && (bus.req_rs2 == '0);
        w_ovf      = (w_op inside {OP_DIV, OP_REM}) && (bus.req_rs1 == INT_MIN) &&
                     (bus.req_rs2 == ALL_ONES);
        // funct3[1] separates REM* from DIV*
        if (w_div_zero)
            w_fast_result = bus.req_funct3[1] ? bus.req_rs1 : ALL_ONES;
        else
            w_fast_result = bus.req_funct3[1] ? '0 : INT_MIN;
    end

    mdu_step #(.XLEN(XLEN)) u_step (
        .i_mode_div (is_div(r_op)),
        .i_acc      (r_acc),
        .i_lo       (r_lo),
        .i_opnd     (r_opnd),
        .o_acc      (w_acc_next),
        .o_lo       (w_lo_next)
    );

    // Final-iteration result: sign fix on the step outputs, then word select
    always_comb begin
        w_rem      = w_acc_next[XLEN-1:0];
        w_prod     = {w_acc_next[XLEN-1:0], w_lo_next};
        w_prod_fix = r_neg ? -w_prod : w_prod;
        case (r_op)
            OP_MUL:                       w_final = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_final = r_neg ? -w_lo_next : w_lo_next;
            default:                      w_final = r_neg ? -w_rem : w_rem;
        endcase
    end

    // Sequencer FSM with datapath registers; flush overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_rd     <= '0;
        end else if (bus.flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_op   <= w_op;
                    r_rd   <= bus.req_rd;
                    r_neg  <= w_neg_req;
                    r_cnt  <= '0;
                    r_acc  <= '0;
                    r_lo   <= is_div(w_op) ? w_mag1 : w_mag2;
                    r_opnd <= is_div(w_op) ? w_mag2 : w_mag1;
                    if (w_div_zero || w_ovf) begin
                        r_result <= w_fast_result;
                        r_state  <= DONE;
                    end else begin
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_lo  <= w_lo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_IT) begin
                        r_result <= w_final;
                        r_state  <= DONE;
                    end
                end
                DONE: if (bus.resp_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (r_state == IDLE) && !bus.flush;
    assign bus.resp_valid  = (r_state == DONE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.resp_result = r_result;
    assign bus.resp_rd     = r_rd;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table of M-ops with hand-computed
// results and latencies, plus back-pressure, flush and mid-op reset sequences.
module tb_mdu_seq;
    import riscy_pkg::*;

    localparam int XW = 32;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_seq_if #(.XLEN(XW), .TAG_W(TW)) bus ();

    mdu_seq #(.XLEN(XW), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input mdu_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = name; v.f3 = op; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Issue one op, scramble inputs after accept, wait for the response
    // (bounded) and optionally complete the handshake.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit release_resp,
                         output logic [31:0] res, output logic [4:0] rdo, output int lat);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.req_rd     = rd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'($urandom);
        bus.req_rs1    = $urandom;
        bus.req_rs2    = $urandom;
        bus.req_rd     = 5'($urandom);
        lat = 1;
        while (!bus.resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = bus.resp_result;
        rdo = bus.resp_rd;
        if (bus.resp_valid && release_resp) begin
            bus.resp_ready = 1'b1;
            @(negedge clk);
            bus.resp_ready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          seen;

        bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_funct3 = '0;
        bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rd = '0; bus.resp_ready = 1'b0;

        add("mul_4x6",        OP_MUL,    32'd4,        32'd6,        5'd3,  32'd24,       33);
        add("mul_n2xn4",      OP_MUL,    32'hFFFFFFFE, 32'hFFFFFFFC, 5'd4,  32'd8,        33);
        add("mul_n3x5",       OP_MUL,    32'hFFFFFFFD, 32'd5,        5'd5,  32'hFFFFFFF1, 33);
        add("mulh_n2xn4",     OP_MULH,   32'hFFFFFFFE, 32'hFFFFFFFC, 5'd6,  32'd0,        33);
        add("mulh_n3x5",      OP_MULH,   32'hFFFFFFFD, 32'd5,        5'd7,  32'hFFFFFFFF, 33);
        add("mulhu_max",      OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 33);
        add("mulhsu_n1x2",    OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd9,  32'hFFFFFFFF, 33);
        add("div_7_n2",       OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 33);
        add("rem_7_n2",       OP_REM,    32'd7,        32'hFFFFFFFE, 5'd11, 32'd1,        33);
        add("div_n7_2",       OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFD, 33);
        add("rem_n7_2",       OP_REM,    32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFF, 33);
        add("divu_100_7",     OP_DIVU,   32'd100,      32'd7,        5'd14, 32'd14,       33);
        add("remu_100_7",     OP_REMU,   32'd100,      32'd7,        5'd15, 32'd2,        33);
        add("divu_max_1",     OP_DIVU,   32'hFFFFFFFF, 32'd1,        5'd16, 32'hFFFFFFFF, 33);
        add("remu_min_3",     OP_REMU,   32'h80000000, 32'd3,        5'd17, 32'd2,        33);
        add("div_by0",        OP_DIV,    32'd1234,     32'd0,        5'd18, 32'hFFFFFFFF, 1);
        add("rem_by0",        OP_REM,    32'd1234,     32'd0,        5'd19, 32'd1234,     1);
        add("divu_by0",       OP_DIVU,   32'd55,       32'd0,        5'd20, 32'hFFFFFFFF, 1);
        add("remu_by0",       OP_REMU,   32'hDEADBEEF, 32'd0,        5'd21, 32'hDEADBEEF, 1);
        add("div_ovf",        OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd22, 32'h80000000, 1);
        add("rem_ovf",        OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd23, 32'd0,        1);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready",   32'(bus.req_ready),  32'd1);
        check("rst_resp_valid",  32'(bus.resp_valid), 32'd0);
        check("rst_busy",        32'(bus.busy),       32'd0);
        check("rst_resp_result", bus.resp_result,     32'd0);
        check("rst_resp_rd",     32'(bus.resp_rd),    32'd0);
        rst_n = 1'b1;

        // Vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1, res, rdo, lat);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_rd"}, 32'(rdo), 32'(vecs[i].rd));
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
            check({vecs[i].name, "_idle_after"}, 32'(bus.busy), 32'd0);
            $display("op %-12s a=%h b=%h -> res=%h rd=%0d lat=%0d", vecs[i].name,
                     vecs[i].a, vecs[i].b, res, rdo, lat);
        end

        // Back-pressure: hold DONE for 10 cycles
        do_op(OP_MUL, 32'd4, 32'd6, 5'd9, 1'b0, res, rdo, lat);
        check("bp_first_result", res, 32'd24);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("bp_result",     bus.resp_result,     32'd24);
            check("bp_rd",         32'(bus.resp_rd),    32'd9);
            check("bp_req_ready",  32'(bus.req_ready),  32'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("bp_release_valid", 32'(bus.resp_valid), 32'd0);
        check("bp_release_busy",  32'(bus.busy),       32'd0);
        check("bp_release_ready", 32'(bus.req_ready),  32'd1);
        $display("seq backpressure done");

        // Flush mid-divide
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_funct3 = OP_DIV; bus.req_rs1 = 32'd100;
        bus.req_rs2 = 32'd7; bus.req_rd = 5'd2;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy_after",  32'(bus.busy),       32'd0);
        check("flush_valid_after", 32'(bus.resp_valid), 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("flush_no_resp", 32'(seen), 32'd0);
        bus.flush = 1'b1;
        #1;
        check("flush_blocks_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        do_op(OP_MUL, 32'd4, 32'd6, 5'd1, 1'b1, res, rdo, lat);
        check("post_flush_mul", res, 32'd24);
        check("post_flush_lat", 32'(lat), 32'd33);
        $display("seq flush done: post-flush mul res=%h lat=%0d", res, lat);

        // Reset pulse mid-CALC
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_funct3 = OP_DIVU; bus.req_rs1 = 32'd100;
        bus.req_rs2 = 32'd7; bus.req_rd = 5'd30;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy",   32'(bus.busy),       32'd0);
        check("rstmid_valid",  32'(bus.resp_valid), 32'd0);
        check("rstmid_result", bus.resp_result,     32'd0);
        check("rstmid_rd",     32'(bus.resp_rd),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("rstmid_no_resp", 32'(seen), 32'd0);
        do_op(OP_MUL, 32'hFFFFFFFD, 32'd5, 5'd31, 1'b1, res, rdo, lat);
        check("post_rst_mul", res, 32'hFFFFFFF1);
        check("post_rst_rd",  32'(rdo), 32'd31);
        $display("seq reset-mid-op done: post-reset mul res=%h lat=%0d", res, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multi-cycle sequencer for the RV32M multiply/divide ops (funct7 = 0x01) of the R-type datapath. Single-cycle ALU ops (ADD, SUB, SLL, ...) stay in the combinational R-type unit. MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU are handed here through a valid/ready request, iterated one bit per cycle, and returned through a valid/ready response. The core stalls on `busy`.

## Interface

Parameters:
- `XLEN`, 32: operand and result width.
- `TAG_W`, 5: destination-register tag width.

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low. Names: `clk` and `rst_n`.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: async assert, sync deassert is the top level's job.
- `flush` in 1: synchronous abort of any in-flight op.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when high with `req_valid`.
- `req_funct3` in 3: M-op select, standard RV32M encoding (0 MUL ... 7 REMU).
- `req_rs1`, `req_rs2` in XLEN: operands.
- `req_rd` in TAG_W: destination tag, returned unchanged.
- `resp_valid` out 1: result present.
- `resp_ready` in 1: consumer takes result.
- `resp_result` out XLEN: result.
- `resp_rd` out TAG_W: tag of the result.
- `busy` out 1: high in any state other than IDLE.

## Operation

- FSM states: IDLE, CALC, DONE.
- IDLE: `req_ready = !flush`. On accept, latch the op, the tag, and the operand magnitudes. Latch the result sign:
  - MUL/MULH: sign(rs1) XOR sign(rs2).
  - MULHSU: sign(rs1).
  - DIV: sign(rs1) XOR sign(rs2).
  - REM: sign(rs1).
  - Unsigned ops: 0.
- Accept transitions:
  - Normal case: go to CALC, iteration counter = 0.
  - Divide ops with rs2 == 0: go to DONE directly. Quotient = all-ones; remainder = rs1.
  - DIV/REM with rs1 = 0x80000000 and rs2 = all-ones (overflow): go to DONE directly. Quotient = 0x80000000; remainder = 0.
- CALC, multiply: radix-2 shift-add into a 2·XLEN product register, one bit per cycle.
- CALC, divide: restoring shift-subtract, producing one quotient bit per cycle; remainder register is XLEN+1 bits.
- CALC exit: after XLEN iterations (counter == XLEN-1), apply two's-complement negation if the sign flag is set, select the output word, register it into `resp_result`, and go to DONE.
- Output word select:
  - MUL: low half of the product.
  - MULH*: high half of the product.
  - DIV*: quotient.
  - REM*: remainder.
- DONE: `resp_valid = 1`; result and tag held stable. On `resp_ready`, go to IDLE.
- No back-to-back issue: `req_ready` is low in DONE.
- `flush` (any state): next edge goes to IDLE and `resp_valid` drops. `flush` takes priority over accept and over the response handshake.

## Timing

- Reset values: state IDLE; `req_ready` = 1; `resp_valid` = 0; `busy` = 0; `resp_result` = 0; `resp_rd` = 0; counter = 0.
- Normal op: accepted at edge N; `resp_valid` is high from edge N+XLEN+1 (33 cycles for XLEN = 32).
- Divide-by-zero and overflow fast path: `resp_valid` high from edge N+1.
- `busy` rises the edge after accept and falls the edge after the response handshake or flush.
- Back-pressure: DONE is held indefinitely while `resp_ready` is low. Outputs must not change.
- Reset mid-op: immediate asynchronous return to the reset values; no partial response is emitted.
- Inputs are sampled only at accept. Operand changes afterwards must have no effect.

## Structure

- Shared package `riscy_pkg` holds:
  - `XLEN`.
  - Opcode constants (`OP_R = 7'b0110011`, `F7_MULDIV = 7'h01`).
  - Enum `mdu_op_e` over funct3.
  - Enum `mdu_state_e` {IDLE, CALC, DONE}.
- Sub-module `mdu_step`: combinational single iteration, i.e. one shift-add multiply step or one restoring-divide step, selected by a mode bit. The FSM, counter, and sign fix stay in `mdu_seq`.

## Test plan

- MUL 4×6, then MUL (−2)×(−4): `resp_result` = 24, then 8, each 33 cycles after accept; `resp_rd` echoed.
- MULH (−2)×(−4) → 0. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 7/−2 → 0xFFFFFFFD. REM 7/−2 → 1. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV x/0 → 0xFFFFFFFF and REM x/0 → x, both 1 cycle after accept. DIV 0x80000000/−1 → 0x80000000 and REM → 0.
- `resp_ready` held low 10 cycles in DONE: `resp_valid` and result stable, `req_ready` low. Release: IDLE next edge.
- `flush` at iteration 12 of a DIV: no `resp_valid` ever, `busy` low next edge, a new MUL then completes correctly. Same check with `rst_n` pulsed mid-CALC.
